// File: rtl/m14k_rf_init_wr_pkg.sv
// ---------------------------------------------------------------------------
// m14k_rf_init_wr_pkg
// Shared definitions for the shadow-set register-file write sequencer:
//   - default widths for data, shadow-set index and register index
//   - FSM state encoding (CLEAR sweeps the file, DONE forwards writebacks)
//   - helper describing the legal rf_mask values (highest implemented set)
// ---------------------------------------------------------------------------
package m14k_rf_init_wr_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_SET_W  = 4;
    localparam int RF_REG_W  = 5;

    // Register 0 of every set is hardwired and never written, so the sweep
    // and the register counter always start at 1.
    localparam int RF_REG_FIRST = 1;

    typedef enum logic {
        CLEAR = 1'b0,
        DONE  = 1'b1
    } rf_init_state_t;

    // rf_mask is the highest implemented set index: 1, 2, 4, 8 or 16 sets.
    function automatic logic rf_mask_legal(input logic [RF_SET_W-1:0] mask);
        case (mask)
            4'd0, 4'd1, 4'd3, 4'd7, 4'd15: rf_mask_legal = 1'b1;
            default:                       rf_mask_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/m14k_rf_init_cnt.sv
// ---------------------------------------------------------------------------
// m14k_rf_init_cnt
// Two-level {set, reg} address counter for the initialization sweep.
// reg counts 1..(2**REG_W-1) and wraps back to 1, carrying into set.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (counter -> {0,1})
//   reload      force the counter back to {0,1}; wins over advance
//   advance     step to the next register address
//   rf_mask     highest implemented set index
//   set_cnt     current set index
//   reg_cnt     current register index
//   last        current address is the final one of the sweep {rf_mask, 31}
// ---------------------------------------------------------------------------
module m14k_rf_init_cnt
    import m14k_rf_init_wr_pkg::*;
#(
    parameter int SET_W = RF_SET_W,
    parameter int REG_W = RF_REG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             reload,
    input  logic             advance,
    input  logic [SET_W-1:0] rf_mask,
    output logic [SET_W-1:0] set_cnt,
    output logic [REG_W-1:0] reg_cnt,
    output logic             last
);

    localparam logic [REG_W-1:0] REG_FIRST = REG_W'(RF_REG_FIRST);
    localparam logic [REG_W-1:0] REG_MAX   = {REG_W{1'b1}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_cnt <= '0;
            reg_cnt <= REG_FIRST;
        end else if (reload) begin
            set_cnt <= '0;
            reg_cnt <= REG_FIRST;
        end else if (advance) begin
            if (reg_cnt == REG_MAX) begin
                reg_cnt <= REG_FIRST;
                set_cnt <= set_cnt + 1'b1;
            end else begin
                reg_cnt <= reg_cnt + 1'b1;
            end
        end
    end

    assign last = (set_cnt == rf_mask) && (reg_cnt == REG_MAX);

endmodule

// File: rtl/m14k_rf_init_wr.sv
// ---------------------------------------------------------------------------
// m14k_rf_init_wr
// Write-side sequencer/arbiter for the flop-based shadow-set register file.
// After reset (or init_start while idle) it writes INIT_VALUE to registers
// 1..31 of every implemented set, then forwards pipeline writebacks to the
// RF write port, one cycle registered.
//
// Ports:
//   gclk, greset_n  clock, asynchronous active-low reset
//   rf_mask         highest implemented set index (0,1,3,7,15), quasi-static
//   init_start      request a new sweep (honoured only when idle)
//   wb_valid        writeback request, held by the requester until accepted
//   wb_dest         writeback destination {set, reg}
//   wb_data         writeback data
//   wb_ready        writeback accepted this cycle (idle state)
//   mpc_dest_w      RF write destination {set, reg}
//   mpc_rfwrite_w   RF write enable
//   edp_wrdata_w    RF write data
//   init_busy       sweep in progress
//   init_done       sweep finished; sticky until the next sweep starts
// ---------------------------------------------------------------------------
module m14k_rf_init_wr
    import m14k_rf_init_wr_pkg::*;
#(
    parameter int                DATA_W     = RF_DATA_W,
    parameter int                SET_W      = RF_SET_W,
    parameter int                REG_W      = RF_REG_W,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic                   gclk,
    input  logic                   greset_n,
    input  logic [SET_W-1:0]       rf_mask,
    input  logic                   init_start,
    input  logic                   wb_valid,
    input  logic [SET_W+REG_W-1:0] wb_dest,
    input  logic [DATA_W-1:0]      wb_data,
    output logic                   wb_ready,
    output logic [SET_W+REG_W-1:0] mpc_dest_w,
    output logic                   mpc_rfwrite_w,
    output logic [DATA_W-1:0]      edp_wrdata_w,
    output logic                   init_busy,
    output logic                   init_done
);

    rf_init_state_t   state;
    logic [SET_W-1:0] set_cnt;
    logic [REG_W-1:0] reg_cnt;
    logic             last;
    logic             cnt_reload;
    logic             cnt_advance;
    logic [SET_W-1:0] wb_set;
    logic [REG_W-1:0] wb_reg;

    assign wb_set = wb_dest[SET_W+REG_W-1:REG_W];
    assign wb_reg = wb_dest[REG_W-1:0];

    // Reload both at the end of a sweep (so an idle counter sits at {0,1})
    // and when a new sweep is launched from the idle state.
    assign cnt_advance = (state == CLEAR);
    assign cnt_reload  = ((state == CLEAR) && last) ||
                         ((state == DONE)  && init_start);

    m14k_rf_init_cnt #(
        .SET_W (SET_W),
        .REG_W (REG_W)
    ) u_cnt (
        .clk     (gclk),
        .rst_n   (greset_n),
        .reload  (cnt_reload),
        .advance (cnt_advance),
        .rf_mask (rf_mask),
        .set_cnt (set_cnt),
        .reg_cnt (reg_cnt),
        .last    (last)
    );

    always_ff @(posedge gclk or negedge greset_n) begin
        if (!greset_n) begin
            state         <= CLEAR;
            mpc_rfwrite_w <= 1'b0;
            mpc_dest_w    <= '0;
            edp_wrdata_w  <= '0;
            init_done     <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    mpc_rfwrite_w <= 1'b1;
                    mpc_dest_w    <= {set_cnt, reg_cnt};
                    edp_wrdata_w  <= INIT_VALUE;
                    // done is raised together with the final sweep write
                    if (last) begin
                        state     <= DONE;
                        init_done <= 1'b1;
                    end
                end
                DONE: begin
                    if (wb_valid) begin
                        // Writes to register 0 are consumed but dropped;
                        // set bits above the implemented range are folded away.
                        mpc_rfwrite_w <= (wb_reg != '0);
                        mpc_dest_w    <= {wb_set & rf_mask, wb_reg};
                        edp_wrdata_w  <= wb_data;
                    end else begin
                        mpc_rfwrite_w <= 1'b0;
                    end
                    if (init_start) begin
                        state     <= CLEAR;
                        init_done <= 1'b0;
                    end
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

    assign init_busy = (state == CLEAR);
    assign wb_ready  = (state == DONE);

endmodule

// File: tb/tb_m14k_rf_init_wr.sv
module tb_m14k_rf_init_wr;

    logic        gclk = 1'b0;
    logic        greset_n;
    logic [3:0]  rf_mask;
    logic        init_start;
    logic        wb_valid;
    logic [8:0]  wb_dest;
    logic [31:0] wb_data;
    logic        wb_ready;
    logic [8:0]  mpc_dest_w;
    logic        mpc_rfwrite_w;
    logic [31:0] edp_wrdata_w;
    logic        init_busy;
    logic        init_done;

    always #5 gclk = ~gclk;

    m14k_rf_init_wr dut (
        .gclk          (gclk),
        .greset_n      (greset_n),
        .rf_mask       (rf_mask),
        .init_start    (init_start),
        .wb_valid      (wb_valid),
        .wb_dest       (wb_dest),
        .wb_data       (wb_data),
        .wb_ready      (wb_ready),
        .mpc_dest_w    (mpc_dest_w),
        .mpc_rfwrite_w (mpc_rfwrite_w),
        .edp_wrdata_w  (edp_wrdata_w),
        .init_busy     (init_busy),
        .init_done     (init_done)
    );

    // Expected RF port writes, in order.
    typedef struct {
        logic [8:0]  dest;
        logic [31:0] data;
        bit          last;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    bit   busy  = 1'b1;   // model: a sweep is in progress
    bit   done  = 1'b0;   // model: sticky sweep-complete flag

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // A sweep writes registers 1..31 of sets 0..mask, all with value 0.
    task automatic push_sweep(input logic [3:0] m);
        for (int s = 0; s <= int'(m); s++) begin
            for (int r = 1; r <= 31; r++) begin
                exp_t e;
                e.dest = {4'(s), 5'(r)};
                e.data = 32'h0;
                e.last = (s == int'(m)) && (r == 31);
                q.push_back(e);
            end
        end
    endtask

    // Monitor / scoreboard
    always @(negedge gclk) begin
        exp_t e;
        if (!greset_n) begin
            chk("rst_rfwrite", 32'(mpc_rfwrite_w), 32'd0);
            chk("rst_dest",    32'(mpc_dest_w),    32'd0);
            chk("rst_data",    edp_wrdata_w,       32'd0);
            chk("rst_done",    32'(init_done),     32'd0);
            chk("rst_busy",    32'(init_busy),     32'd1);
            chk("rst_ready",   32'(wb_ready),      32'd0);
        end else begin
            if (mpc_rfwrite_w === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_write", 32'(mpc_dest_w), 32'h1ff);
                end else begin
                    e = q.pop_front();
                    chk("wr_dest", 32'(mpc_dest_w), 32'(e.dest));
                    chk("wr_data", edp_wrdata_w, e.data);
                    if (e.last) begin
                        busy = 1'b0;
                        done = 1'b1;
                    end
                end
            end
            chk("init_busy", 32'(init_busy), 32'(busy));
            chk("init_done", 32'(init_done), 32'(done));
            chk("wb_ready",  32'(wb_ready),  32'(!busy));
        end
    end

    // One clock of stimulus; entered and left at posedge+1.
    task automatic cycle(input bit v, input logic [8:0] d, input logic [31:0] dat,
                         input bit st, output bit acc);
        wb_valid   = v;
        wb_dest    = d;
        wb_data    = dat;
        init_start = st;
        @(negedge gclk);
        #1;
        acc = !busy;
        @(posedge gclk);
        #1;
        if (acc && v && (d[4:0] != 5'd0))
            q.push_back('{dest: {d[8:5] & rf_mask, d[4:0]}, data: dat, last: 1'b0});
        if (acc && st) begin
            busy = 1'b1;
            done = 1'b0;
            push_sweep(rf_mask);
        end
        wb_valid   = 1'b0;
        init_start = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 9'h0, 32'h0, 1'b0, acc);
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            idle(1);
            n++;
        end
        if (busy) chk("sweep_timeout", 32'd1, 32'd0);
    endtask

    // Hold a writeback until accepted, bounded.
    task automatic send_wb(input logic [8:0] d, input logic [31:0] dat, input int limit);
        bit acc = 1'b0;
        int n = 0;
        while (!acc && n < limit) begin
            cycle(1'b1, d, dat, 1'b0, acc);
            n++;
        end
        if (!acc) chk("wb_accept_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_reset(input int ncyc);
        greset_n = 1'b0;
        #1;
        chk("async_rfwrite", 32'(mpc_rfwrite_w), 32'd0);
        chk("async_dest",    32'(mpc_dest_w),    32'd0);
        chk("async_busy",    32'(init_busy),     32'd1);
        chk("async_done",    32'(init_done),     32'd0);
        q.delete();
        busy = 1'b1;
        done = 1'b0;
        repeat (ncyc) @(posedge gclk);
        #1;
        greset_n = 1'b1;
        push_sweep(rf_mask);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, pending %0d", q.size());
        $fatal(1, "watchdog");
    end

    logic [3:0] masks [5] = '{4'd0, 4'd1, 4'd3, 4'd7, 4'd15};

    initial begin
        bit acc;
        greset_n   = 1'b0;
        rf_mask    = 4'hF;
        init_start = 1'b0;
        wb_valid   = 1'b0;
        wb_dest    = '0;
        wb_data    = '0;
        repeat (3) @(posedge gclk);
        #1;
        greset_n = 1'b1;
        push_sweep(rf_mask);

        // Writeback held through the whole sweep; must be the first non-init write.
        send_wb(9'h025, 32'hDEADBEEF, 700);
        // Register 0 destination: consumed, not written.
        send_wb(9'h020, 32'h12345678, 4);
        idle(2);
        // Set index folded by rf_mask.
        rf_mask = 4'h3;
        send_wb(9'h1E7, 32'hCAFEF00D, 4);
        idle(2);

        // Re-init with two sets, together with an accepted writeback.
        rf_mask = 4'h1;
        cycle(1'b1, 9'h0A3, 32'hA5A5A5A5, 1'b1, acc);
        chk("start_accepted", 32'(acc), 32'd1);
        wait_done(200);
        idle(2);

        // Randomized traffic in the idle state, occasional masks and restarts.
        for (int i = 0; i < 400; i++) begin
            bit v  = ($urandom_range(0, 1) == 1);
            bit st = ($urandom_range(0, 59) == 0);
            if (!busy && !st && $urandom_range(0, 19) == 0)
                rf_mask = masks[$urandom_range(0, 4)];
            cycle(v, 9'($urandom), $urandom, st, acc);
        end
        wait_done(600);

        // Full sweep, spurious init_start at cycle 200, then reset mid-sweep.
        rf_mask = 4'hF;
        cycle(1'b0, 9'h0, 32'h0, 1'b1, acc);
        idle(199);
        cycle(1'b0, 9'h0, 32'h0, 1'b1, acc);
        do_reset(2);
        wait_done(600);
        idle(3);

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
